// File: rtl/por_seq_multi_if.sv
// Rail-monitor / reset-domain bundle between the POR sequencer (slave) and its environment (master).
// Carries fault_cnt only when POR_SEQ_FAULT_CNT_EN is defined.
interface por_seq_multi_if #(parameter int NCH = 3);
  logic [NCH-1:0] pwup_comp;
  logic [2:0]     otrip;
  logic           force_short_oneshot;
  logic           force_pdn;
  logic [NCH-1:0] porb;
  logic           por_any;
  logic [NCH-1:0] pwup_filt;
  logic           startup_timed_out;
  logic           por_timed_out;
  logic [2:0]     seq_state;
`ifdef POR_SEQ_FAULT_CNT_EN
  logic [7:0]     fault_cnt;

  modport master (output pwup_comp, otrip, force_short_oneshot, force_pdn,
                  input  porb, por_any, pwup_filt, startup_timed_out, por_timed_out, seq_state,
                         fault_cnt);
  modport slave  (input  pwup_comp, otrip, force_short_oneshot, force_pdn,
                  output porb, por_any, pwup_filt, startup_timed_out, por_timed_out, seq_state,
                         fault_cnt);
`else
  modport master (output pwup_comp, otrip, force_short_oneshot, force_pdn,
                  input  porb, por_any, pwup_filt, startup_timed_out, por_timed_out, seq_state);
  modport slave  (input  pwup_comp, otrip, force_short_oneshot, force_pdn,
                  output porb, por_any, pwup_filt, startup_timed_out, por_timed_out, seq_state);
`endif
endinterface

// File: rtl/por_seq_multi.sv
// Multi-rail POR sequencer: sync + debounce rail-good flags, hold, then release resets in index order.
// Optional brownout counter output fault_cnt is built when POR_SEQ_FAULT_CNT_EN is defined.
module por_seq_multi #(
  parameter int NCH         = 3,
  parameter int CNT_W       = 16,
  parameter int DEB_CYC     = 8,
  parameter int HOLD_CYC    = 1024,
  parameter int STAGGER_CYC = 16,
  parameter int TIMEOUT_CYC = 60000
) (
  input logic            osc_ck,
  input logic            por,
  por_seq_multi_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, WAIT_UP = 3'd1, HOLD = 3'd2, RELEASE = 3'd3, RUN = 3'd4
  } state_t;

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]      r_sync1, r_sync2, r_filt;
  logic [NCH-1:0][7:0] r_deb_cnt;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [2:0]          r_otrip;
  logic [NCH-1:0]      r_porb;
  logic                r_por_any, r_tmo, r_pto;
`ifdef POR_SEQ_FAULT_CNT_EN
  logic [7:0]          r_fault_cnt;
`endif

  logic                w_all_up, w_brownout;
  logic [CNT_W-1:0]    w_hold_sh, w_hold, w_stag, w_cnt_sat;
  logic [IDX_W-1:0]    w_idx_nx;

  // Rise needs DEB_CYC consecutive synced highs; a single synced low drops the flag at once.
  always_ff @(posedge osc_ck) begin
    if (por) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_filt    <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bus.pwup_comp;
      r_sync2 <= r_sync1;
      for (int c = 0; c < NCH; c++) begin
        if (!r_sync2[c]) begin
          r_deb_cnt[c] <= 8'd0;
          r_filt[c]    <= 1'b0;
        end else if (r_deb_cnt[c] == 8'(DEB_CYC - 1)) begin
          r_filt[c]    <= 1'b1;
        end else begin
          r_deb_cnt[c] <= r_deb_cnt[c] + 8'd1;
        end
      end
    end
  end

  assign w_all_up   = &r_filt;
  assign w_brownout = (r_state == HOLD || r_state == RELEASE || r_state == RUN) && !w_all_up;
  assign w_hold_sh  = CNT_W'(HOLD_CYC) << r_otrip;
  assign w_hold     = bus.force_short_oneshot ? CNT_W'(4)
                    : ((w_hold_sh == '0) ? CNT_W'(1) : w_hold_sh);
  assign w_stag     = bus.force_short_oneshot ? CNT_W'(1) : CNT_W'(STAGGER_CYC);
  assign w_cnt_sat  = (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_idx_nx   = r_idx + IDX_W'(1);

  always_ff @(posedge osc_ck) begin
    if (por) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_otrip     <= 3'd0;
      r_porb      <= '0;
      r_por_any   <= 1'b1;
      r_tmo       <= 1'b0;
      r_pto       <= 1'b0;
`ifdef POR_SEQ_FAULT_CNT_EN
      r_fault_cnt <= 8'd0;
`endif
    end else begin
      r_pto <= 1'b0;
      if (bus.force_pdn) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_idx     <= '0;
        r_porb    <= '0;
        r_por_any <= 1'b1;
      end else if (w_brownout) begin
        r_state   <= WAIT_UP;
        r_cnt     <= '0;
        r_idx     <= '0;
        r_porb    <= '0;
        r_por_any <= 1'b1;
`ifdef POR_SEQ_FAULT_CNT_EN
        if (r_fault_cnt != 8'hFF) r_fault_cnt <= r_fault_cnt + 8'd1;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= WAIT_UP;
            r_cnt   <= '0;
          end
          WAIT_UP: begin
            if (w_all_up) begin
              r_state <= HOLD;
              r_cnt   <= '0;
              r_otrip <= bus.otrip;
            end else begin
              // Counter parks at TIMEOUT_CYC-1 so the flag is raised exactly once per wait.
              r_cnt <= w_cnt_sat;
              if (w_cnt_sat == CNT_W'(TIMEOUT_CYC - 1)) r_tmo <= 1'b1;
            end
          end
          HOLD: begin
            if (r_cnt == w_hold - CNT_W'(1)) begin
              r_state   <= RELEASE;
              r_cnt     <= '0;
              r_idx     <= '0;
              r_pto     <= 1'b1;
              r_porb[0] <= 1'b1;
              r_por_any <= (NCH > 1);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RELEASE: begin
            if (int'(r_idx) == NCH - 1) begin
              r_state <= RUN;
            end else if (r_cnt == w_stag - CNT_W'(1)) begin
              r_cnt            <= '0;
              r_idx            <= w_idx_nx;
              r_porb[w_idx_nx] <= 1'b1;
              r_por_any        <= (int'(w_idx_nx) != NCH - 1);
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          RUN:     r_state <= RUN;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.porb              = r_porb;
  assign bus.por_any           = r_por_any;
  assign bus.pwup_filt         = r_filt;
  assign bus.startup_timed_out = r_tmo;
  assign bus.por_timed_out     = r_pto;
  assign bus.seq_state         = r_state;
`ifdef POR_SEQ_FAULT_CNT_EN
  assign bus.fault_cnt         = r_fault_cnt;
`endif
endmodule

// File: tb/tb_por_seq_multi.sv
// Directed bench for por_seq_multi: timestamp-based reference model checked every cycle,
// plus literal latency/value checks for cold start, glitch, brownout, timeout, hold scaling, priorities.
module tb_por_seq_multi;
  localparam int NCH = 3, CNT_W = 16, DEB = 8, HOLDC = 16, STAG = 3, TMO = 100;
  localparam int M_IDLE = 0, M_WAIT = 1, M_HOLD = 2, M_SEQ = 3;
  localparam int W_STATE = 0, W_PTO = 1, W_FILT = 2, W_PORB = 3;

  logic osc_ck = 1'b0;
  logic por    = 1'b1;

  por_seq_multi_if #(.NCH(NCH)) bus ();

  por_seq_multi #(
    .NCH(NCH), .CNT_W(CNT_W), .DEB_CYC(DEB), .HOLD_CYC(HOLDC),
    .STAGGER_CYC(STAG), .TIMEOUT_CYC(TMO)
  ) dut (
    .osc_ck(osc_ck),
    .por   (por),
    .bus   (bus)
  );

  always #5 osc_ck = ~osc_ck;

  int errs = 0, checks = 0;

  // Reference model state: rail-high run lengths and timestamps of the current phase.
  int             run [NCH], run_d1 [NCH], run_d2 [NCH];
  int             m_mode, m_t, m_h, m_s, m_edge;
  bit             m_ok;
  logic [NCH-1:0] e_filt, e_porb;
  logic           e_tmo, e_pto;
  logic [2:0]     e_state;
  int             e_fault;

  initial begin
    longint         hv;
    logic [NCH-1:0] fprev;
    m_ok = 0; m_edge = 0; m_mode = M_IDLE; m_t = 0; m_h = 1; m_s = 1;
    e_filt = '0; e_porb = '0; e_tmo = 0; e_pto = 0; e_state = 3'd0; e_fault = 0;
    for (int c = 0; c < NCH; c++) begin run[c] = 0; run_d1[c] = 0; run_d2[c] = 0; end
    forever begin
      @(posedge osc_ck);
      m_edge++;
      fprev = e_filt;
      for (int c = 0; c < NCH; c++) begin
        run_d2[c] = run_d1[c];
        run_d1[c] = run[c];
        run[c]    = bus.pwup_comp[c] ? ((run[c] < 1000) ? run[c] + 1 : run[c]) : 0;
      end
      if (por) begin
        for (int c = 0; c < NCH; c++) begin run[c] = 0; run_d1[c] = 0; run_d2[c] = 0; end
        m_mode = M_IDLE; e_filt = '0; e_tmo = 0; e_pto = 0; e_fault = 0; m_ok = 1;
      end else begin
        // A rail is good once its last DEB samples (seen through two sync stages) were all high.
        for (int c = 0; c < NCH; c++) e_filt[c] = (run_d2[c] >= DEB);
        e_pto = 0;
        if (bus.force_pdn) begin
          m_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
          m_mode = M_WAIT; m_t = m_edge;
        end else if (m_mode == M_WAIT) begin
          if (&fprev) begin
            hv     = (longint'(HOLDC) << bus.otrip) & ((longint'(1) << CNT_W) - 1);
            m_h    = bus.force_short_oneshot ? 4 : ((hv == 0) ? 1 : int'(hv));
            m_mode = M_HOLD; m_t = m_edge;
          end else if (m_edge - m_t >= TMO - 1) begin
            e_tmo = 1;
          end
        end else if (!(&fprev)) begin
          m_mode = M_WAIT; m_t = m_edge;
          if (e_fault < 255) e_fault++;
        end else if (m_mode == M_HOLD && m_edge - m_t == m_h) begin
          m_mode = M_SEQ; m_t = m_edge; e_pto = 1;
          m_s = bus.force_short_oneshot ? 1 : STAG;
        end
      end
      e_porb = '0;
      if (m_mode == M_SEQ)
        for (int k = 0; k < NCH; k++) e_porb[k] = (m_edge - m_t >= k * m_s);
      case (m_mode)
        M_IDLE:  e_state = 3'd0;
        M_WAIT:  e_state = 3'd1;
        M_HOLD:  e_state = 3'd2;
        default: e_state = (m_edge - m_t > (NCH - 1) * m_s) ? 3'd4 : 3'd3;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge osc_ck);
      if (m_ok) begin
        checks++;
        if ({bus.porb, bus.por_any, bus.pwup_filt, bus.startup_timed_out, bus.por_timed_out, bus.seq_state}
            !== {e_porb, ~&e_porb, e_filt, e_tmo, e_pto, e_state}) begin
          errs++;
          $display("FAIL model t=%0t: got porb=%b any=%b filt=%b tmo=%b pto=%b st=%0d exp porb=%b any=%b filt=%b tmo=%b pto=%b st=%0d",
                   $time, bus.porb, bus.por_any, bus.pwup_filt, bus.startup_timed_out, bus.por_timed_out,
                   bus.seq_state, e_porb, ~&e_porb, e_filt, e_tmo, e_pto, e_state);
        end
`ifdef POR_SEQ_FAULT_CNT_EN
        checks++;
        if (bus.fault_cnt !== 8'(e_fault)) begin
          errs++;
          $display("FAIL model fault_cnt t=%0t: got %0d exp %0d", $time, bus.fault_cnt, e_fault);
        end
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge osc_ck);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] sel(input int w);
    case (w)
      W_STATE: return 32'(bus.seq_state);
      W_PTO:   return 32'(bus.por_timed_out);
      W_FILT:  return 32'(bus.pwup_filt);
      default: return 32'(bus.porb);
    endcase
  endfunction

  task automatic wait_sig(input string nm, input int w, input logic [31:0] v, input int maxc, output int n);
    n = 0;
    while (sel(w) !== v && n < maxc) begin tick(1); n++; end
    if (sel(w) !== v) begin
      checks++; errs++;
      $display("FAIL wait %s: got %0h need %0h within %0d cycles", nm, sel(w), v, maxc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.pwup_comp = '0; bus.otrip = 3'd0; bus.force_short_oneshot = 1'b1; bus.force_pdn = 1'b0;
    por = 1'b1;
    tick(3);
    chk("rst porb", 32'(bus.porb), 32'h0);
    chk("rst por_any", 32'(bus.por_any), 32'h1);
    chk("rst filt", 32'(bus.pwup_filt), 32'h0);
    chk("rst tmo", 32'(bus.startup_timed_out), 32'h0);
    chk("rst pto", 32'(bus.por_timed_out), 32'h0);
    chk("rst state", 32'(bus.seq_state), 32'h0);

    // Cold start, short oneshot
    por = 1'b0; bus.pwup_comp = 3'b111;
    wait_sig("cold filt", W_FILT, 32'h7, 50, n);
    chk("filt rise latency", n, 10);
    wait_sig("cold hold", W_STATE, 32'h2, 10, n);
    chk("hold entry delay", n, 1);
    wait_sig("cold pto", W_PTO, 32'h1, 20, n);
    chk("short hold len", n, 4);
    chk("rel porb0", 32'(bus.porb), 32'h1);
    chk("rel any0", 32'(bus.por_any), 32'h1);
    tick(1);
    chk("rel porb1", 32'(bus.porb), 32'h3);
    chk("rel any1", 32'(bus.por_any), 32'h1);
    tick(1);
    chk("rel porb2", 32'(bus.porb), 32'h7);
    chk("rel any2", 32'(bus.por_any), 32'h0);
    tick(1);
    chk("run state", 32'(bus.seq_state), 32'h4);

    // One-cycle brownout on rail 2
    bus.pwup_comp = 3'b011; tick(1); bus.pwup_comp = 3'b111;
    wait_sig("brownout porb", W_PORB, 32'h0, 10, n);
    chk("brownout latency", n, 3);
    chk("brownout state", 32'(bus.seq_state), 32'h1);
    wait_sig("resequence", W_STATE, 32'h4, 60, n);
    chk("resequence porb", 32'(bus.porb), 32'h7);
`ifdef POR_SEQ_FAULT_CNT_EN
    chk("fault_cnt 1", 32'(bus.fault_cnt), 32'h1);
`endif

    // Glitch on rail 1, then scaled hold with otrip=3
    bus.force_short_oneshot = 1'b0; bus.otrip = 3'd3;
    bus.pwup_comp = 3'b101;
    wait_sig("glitch brownout", W_STATE, 32'h1, 10, n);
    tick(3);
    bus.pwup_comp = 3'b111; tick(5);
    bus.pwup_comp = 3'b101; tick(1);
    bus.pwup_comp = 3'b111;
    tick(9);
    chk("glitch filt early", 32'(bus.pwup_filt[1]), 32'h0);
    chk("glitch no hold", 32'(bus.seq_state), 32'h1);
    tick(1);
    chk("glitch filt rise", 32'(bus.pwup_filt[1]), 32'h1);
    wait_sig("scaled hold entry", W_STATE, 32'h2, 5, n);
    chk("scaled hold entry delay", n, 1);
    tick(10);
    bus.otrip = 3'd0;
    wait_sig("scaled pto", W_PTO, 32'h1, 200, n);
    chk("scaled hold len", n + 10, 128);
    wait_sig("stagger", W_PORB, 32'h7, 20, n);
    chk("stagger span", n, 6);

    // Startup timeout with rail 0 held low
    bus.force_short_oneshot = 1'b1;
    bus.pwup_comp = 3'b110;
    wait_sig("tmo wait", W_STATE, 32'h1, 10, n);
    tick(98);
    chk("tmo before", 32'(bus.startup_timed_out), 32'h0);
    tick(1);
    chk("tmo at 99", 32'(bus.startup_timed_out), 32'h1);
    bus.pwup_comp = 3'b111;
    wait_sig("tmo recover", W_STATE, 32'h4, 60, n);
    chk("tmo sticky", 32'(bus.startup_timed_out), 32'h1);

    // force_pdn during RELEASE
    bus.force_short_oneshot = 1'b0;
    bus.pwup_comp = 3'b011; tick(1); bus.pwup_comp = 3'b111;
    wait_sig("pdn release", W_PORB, 32'h1, 80, n);
    bus.force_pdn = 1'b1;
    tick(1);
    chk("pdn porb", 32'(bus.porb), 32'h0);
    chk("pdn state", 32'(bus.seq_state), 32'h0);
    chk("pdn any", 32'(bus.por_any), 32'h1);
    tick(1);
    chk("pdn held", 32'(bus.seq_state), 32'h0);
    bus.force_pdn = 1'b0;
    tick(1);
    chk("pdn resume", 32'(bus.seq_state), 32'h1);
`ifdef POR_SEQ_FAULT_CNT_EN
    chk("fault_cnt pdn", 32'(bus.fault_cnt), 32'h4);
`endif

    // por mid-HOLD
    wait_sig("por hold", W_STATE, 32'h2, 10, n);
    tick(3);
    por = 1'b1;
    tick(1);
    chk("por porb", 32'(bus.porb), 32'h0);
    chk("por any", 32'(bus.por_any), 32'h1);
    chk("por filt", 32'(bus.pwup_filt), 32'h0);
    chk("por tmo", 32'(bus.startup_timed_out), 32'h0);
    chk("por pto", 32'(bus.por_timed_out), 32'h0);
    chk("por state", 32'(bus.seq_state), 32'h0);
`ifdef POR_SEQ_FAULT_CNT_EN
    chk("por fault_cnt", 32'(bus.fault_cnt), 32'h0);
`endif
    por = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
